// File: rtl/alu_mc_pkg.sv
// alu_mc_defs: shared opcode/state enums and the iterative-op mask for alu_mc
package alu_mc_defs;
  typedef enum logic [2:0] {ADD, SUB, MOV_A, MOV_B, AND, OR, MUL, DIV} op_e;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
  localparam logic [7:0] OP_ITER_MASK = 8'b1100_0000;
endpackage

// File: rtl/alu_mc_iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
module iter_muldiv #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         mode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] lo_o,
  output logic [N-1:0] hi_o,
  output logic         last_o
);
  logic [N-1:0]  acc, q, m;
  logic [CW-1:0] cnt;
  logic [N:0]    sum, rem, diff;
  // lo_o/hi_o present the pair as it will be after the current step, so the top can capture the final step directly
  always_comb begin
    sum    = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem    = {acc, q[N-1]};
    diff   = rem - {1'b0, m};
    hi_o   = mode_i ? (diff[N] ? rem[N-1:0] : diff[N-1:0]) : sum[N:1];
    lo_o   = mode_i ? {q[N-2:0], ~diff[N]} : {sum[0], q[N-1:1]};
    last_o = cnt == CW'(1);
  end
  // accumulator/remainder, multiplier/quotient, operand and step counter registers
  always_ff @(posedge clk_i)
    if (rst_i) begin
      acc <= '0;
      q   <= '0;
      m   <= '0;
      cnt <= '0;
    end else if (load_i) begin
      acc <= '0;
      q   <= a_i;
      m   <= b_i;
      cnt <= CW'(N);
    end else if (step_i) begin
      acc <= hi_o;
      q   <= lo_o;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with registered results/flags and start/done handshake
module alu_mc
  import alu_mc_defs::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   opcode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic [N-1:0] hi_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         c_o,
  output logic         z_o,
  output logic         n_o,
  output logic         v_o
);
  state_e       state, state_n;
  op_e          op;
  logic         accept, div0, go_iter, step, finish, mode_q;
  logic         md_last, nc, nv, ovf;
  logic [N-1:0] md_lo, md_hi, bb, nres, nhi;
  logic [N:0]   sum;
  iter_muldiv #(.N(N), .CW(CW)) u_md (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (go_iter),
    .step_i (step),
    .mode_i (mode_q),
    .a_i    (a_i),
    .b_i    (b_i),
    .lo_o   (md_lo),
    .hi_o   (md_hi),
    .last_o (md_last)
  );
  // handshake decode and next state; start is ignored while iterating
  always_comb begin
    op      = op_e'(opcode_i);
    accept  = start_i && state != ITER;
    div0    = op == DIV && b_i == '0;
    go_iter = accept && OP_ITER_MASK[opcode_i] && !div0;
    step    = state == ITER;
    finish  = step && md_last;
    state_n = go_iter ? ITER : (accept || finish) ? DONE : step ? ITER : IDLE;
  end
  // single-cycle datapath and the values to capture on completion
  always_comb begin
    bb   = op == SUB ? ~b_i : b_i;
    sum  = {1'b0, a_i} + {1'b0, bb} + {{N{1'b0}}, op == SUB};
    ovf  = (a_i[N-1] == bb[N-1]) && (sum[N-1] != a_i[N-1]);
    nres = '0;
    nhi  = '0;
    nc   = 1'b0;
    nv   = 1'b0;
    if (finish) begin
      nres = md_lo;
      nhi  = md_hi;
      nv   = !mode_q && md_hi != '0;
    end else
      case (op)
        ADD, SUB: begin
          nres = sum[N-1:0];
          nc   = sum[N];
          nv   = ovf;
        end
        MOV_A: nres = a_i;
        MOV_B: nres = b_i;
        AND:   nres = a_i & b_i;
        OR:    nres = a_i | b_i;
        DIV: begin
          nres = '1;
          nhi  = a_i;
          nv   = 1'b1;
        end
        default: ;
      endcase
  end
  // state, iterative mode and output/flag registers; outputs hold between completions
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      result_o <= '0;
      hi_o     <= '0;
      c_o      <= 1'b0;
      z_o      <= 1'b0;
      n_o      <= 1'b0;
      v_o      <= 1'b0;
    end else begin
      state <= state_n;
      if (go_iter) mode_q <= op == DIV;
      if ((accept && !go_iter) || finish) begin
        result_o <= nres;
        hi_o     <= nhi;
        c_o      <= nc;
        z_o      <= nres == '0;
        n_o      <= nres[N-1];
        v_o      <= nv;
      end
    end
  assign busy_o = state == ITER;
  assign done_o = state == DONE;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against a behavioural model
module tb_alu_mc;
  localparam int N = 8;
  localparam int MASK = (1 << N) - 1;
  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] opcode;
  logic [N-1:0] a, b;
  logic [N-1:0] result_o, hi_o;
  logic busy_o, done_o, c_o, z_o, n_o, v_o;
  int n_err = 0;
  int n_chk = 0;
  logic cmp_en = 1'b0;

  alu_mc dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opcode),
    .a_i(a), .b_i(b), .result_o(result_o), .hi_o(hi_o),
    .busy_o(busy_o), .done_o(done_o),
    .c_o(c_o), .z_o(z_o), .n_o(n_o), .v_o(v_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return x >= (1 << (N - 1)) ? x - (1 << N) : x;
  endfunction

  // Behavioural model: transaction level, remaining-cycle counter for iterative ops
  int m_cnt, m_res, m_hi, m_c, m_z, m_n, m_v, m_done;
  int p_res, p_hi, p_v;
  int ai, bi, r, h, cy, ov, p, sd;

  task automatic apply(input int rr, input int hh, input int cc, input int vv);
    m_res = rr; m_hi = hh; m_c = cc; m_v = vv;
    m_z = (rr == 0);
    m_n = (rr >> (N - 1)) & 1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 0;
      apply(0, 0, 0, 0);
      m_z = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          apply(p_res, p_hi, 0, p_v);
          m_done = 1;
        end
      end else if (start) begin
        ai = int'(a); bi = int'(b);
        r = 0; h = 0; cy = 0; ov = 0;
        case (opcode)
          3'd0: begin r = ai + bi; cy = (r >> N) & 1; sd = sx(ai) + sx(bi); end
          3'd1: begin r = ai + (MASK - bi) + 1; cy = (r >> N) & 1; sd = sx(ai) - sx(bi); end
          3'd2: r = ai;
          3'd3: r = bi;
          3'd4: r = ai & bi;
          3'd5: r = ai | bi;
          3'd6: begin p = ai * bi; r = p; h = p >> N; ov = (h != 0); end
          default: if (bi == 0) begin r = MASK; h = ai; ov = 1; end
                   else begin r = ai / bi; h = ai % bi; end
        endcase
        if (opcode <= 3'd1) ov = (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
        r = r & MASK;
        h = h & MASK;
        if (opcode >= 3'd6 && !(opcode == 3'd7 && bi == 0)) begin
          m_cnt = N; p_res = r; p_hi = h; p_v = ov;
        end else begin
          apply(r, h, cy, ov);
          m_done = 1;
        end
      end
    end
  end

  // Compare process: every cycle, all outputs against the model
  always @(negedge clk) if (cmp_en) begin
    chk("m_result", int'(result_o), m_res);
    chk("m_hi", int'(hi_o), m_hi);
    chk("m_busy", int'(busy_o), int'(m_cnt > 0));
    chk("m_done", int'(done_o), m_done);
    chk("m_c", int'(c_o), m_c);
    chk("m_z", int'(z_o), m_z);
    chk("m_n", int'(n_o), m_n);
    chk("m_v", int'(v_o), m_v);
    chk("busy_done_excl", int'(busy_o && done_o), 0);
  end

  // Directed op with hand-computed expectations; flags packed {c,z,n,v}
  task automatic run_op(input string nm, input logic bb, input logic [2:0] op,
                        input logic [N-1:0] av, input logic [N-1:0] bv,
                        input int er, input int eh, input int ef, input int elat);
    int lat, bsy;
    if (!bb) @(negedge clk);
    start = 1'b1; opcode = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bsy = 0;
    while (!done_o && lat < 40) begin
      bsy += int'(busy_o);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, bsy, elat - 1);
    chk({nm, "_result"}, int'(result_o), er);
    chk({nm, "_hi"}, int'(hi_o), eh);
    chk({nm, "_flags"}, int'({c_o, z_o, n_o, v_o}), ef);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_result", int'(result_o), 0);
    chk("reset_hi", int'(hi_o), 0);
    chk("reset_ctl", int'({busy_o, done_o, c_o, z_o, n_o, v_o}), 0);

    run_op("add_ovf", 1'b0, 3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0011, 1);
    run_op("sub_borrow", 1'b0, 3'd1, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0010, 1);
    run_op("sub_b2b", 1'b1, 3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 4'b1100, 1);
    run_op("mul_0f_11", 1'b0, 3'd6, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0010, 9);
    run_op("mul_10_10", 1'b0, 3'd6, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0101, 9);
    run_op("div_100_7", 1'b0, 3'd7, 8'd100, 8'd7, 8'h0E, 8'h02, 4'b0000, 9);
    run_op("div_by0", 1'b0, 3'd7, 8'h2A, 8'h00, 8'hFF, 8'h2A, 4'b0011, 1);
    run_op("and", 1'b0, 3'd4, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1);

    @(negedge clk);
    start = 1'b1; opcode = 3'd6; a = 8'h03; b = 8'h05;
    done_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      done_seen += int'(done_o);
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; opcode = 3'd0; a = 8'h11; b = 8'h22; end
      if (i == 4) start = 1'b0;
      if (i == 5) begin chk("abort_busy", int'(busy_o), 1); rst = 1'b1; end
      if (i == 6) begin
        rst = 1'b0;
        chk("abort_no_done", done_seen, 0);
        chk("abort_outputs", int'({result_o, hi_o, busy_o, done_o, c_o, z_o, n_o, v_o}), 0);
      end
    end
    run_op("add_after_abort", 1'b0, 3'd0, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start  = ($urandom % 3) == 0;
      opcode = 3'($urandom);
      a      = 8'($urandom);
      b      = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      rst    = ($urandom % 300) == 0;
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
